cd_cmd_arb: RTL

CD_CMD_ARB -- requirements
Module: cd_cmd_arb

---
 rtl/cd_cmd_arb.sv | 135 +++++++++++++
 1 files changed

// File: rtl/cd_cmd_arb.sv
// Two-requester round-robin command arbiter for a toggle-handshake HPS bridge.
// A granted command is sent with a request toggle, and the arbiter then waits for
// the bridge's acknowledge toggle or a timeout. The result is returned as a
// one-cycle strobe to whichever requester issued the command.
module cd_cmd_arb #(
    parameter logic [23:0] TIMEOUT = 24'd6_000_000
) (
    input  logic        clk_sys,
    input  logic        nRESET,
    input  logic        req0_valid,
    input  logic        req1_valid,
    input  logic [47:0] req0_cmd,
    input  logic [47:0] req1_cmd,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic        resp0_valid,
    output logic        resp1_valid,
    output logic [47:0] resp_data,
    output logic        resp_err,
    output logic [48:0] cd_in,
    input  logic [48:0] cd_out,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [47:0] cmd_q, cmd_d;
    logic        req_tog_q, req_tog_d;
    logic        ack_tog_q, ack_tog_d;
    logic        idx_q, idx_d;
    logic        last_q, last_d;
    logic [23:0] cnt_q, cnt_d;
    logic [47:0] resp_data_q, resp_data_d;
    logic        resp_err_q, resp_err_d;

    logic        gnt_idx;
    logic        accept;
    logic        ack;
    logic        terminal;

    // Round-robin grant and combinational ready; held off while in reset.
    always_comb begin
        gnt_idx    = (req0_valid & req1_valid) ? ~last_q : req1_valid;
        req0_ready = (state_q == StIdle) & nRESET & req0_valid & ~gnt_idx;
        req1_ready = (state_q == StIdle) & nRESET & req1_valid & gnt_idx;
        accept     = req0_ready | req1_ready;
        ack        = cd_out[48] ^ ack_tog_q;
        terminal   = (cnt_q == TIMEOUT - 24'd1);
    end

    // Next-state logic for the handshake FSM and its datapath registers.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        req_tog_d   = req_tog_q;
        ack_tog_d   = ack_tog_q;
        idx_d       = idx_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        unique case (state_q)
            StIdle: begin
                // Track the acknowledge line so a late toggle is swallowed.
                ack_tog_d = cd_out[48];
                if (accept) begin
                    cmd_d     = gnt_idx ? req1_cmd : req0_cmd;
                    req_tog_d = ~req_tog_q;
                    idx_d     = gnt_idx;
                    last_d    = gnt_idx;
                    cnt_d     = 24'd0;
                    state_d   = StWait;
                end
            end
            StWait: begin
                // Acknowledge takes priority over the terminal count.
                if (ack) begin
                    resp_data_d = cd_out[47:0];
                    resp_err_d  = 1'b0;
                    ack_tog_d   = cd_out[48];
                    state_d     = StResp;
                end else if (terminal) begin
                    resp_data_d = 48'd0;
                    resp_err_d  = 1'b1;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            state_q     <= StIdle;
            cmd_q       <= 48'd0;
            req_tog_q   <= 1'b0;
            ack_tog_q   <= 1'b0;
            idx_q       <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= 24'd0;
            resp_data_q <= 48'd0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            req_tog_q   <= req_tog_d;
            ack_tog_q   <= ack_tog_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    // Registered outputs and state-decoded strobes.
    always_comb begin
        cd_in       = {req_tog_q, cmd_q};
        resp_data   = resp_data_q;
        resp_err    = resp_err_q;
        resp0_valid = (state_q == StResp) & ~idx_q;
        resp1_valid = (state_q == StResp) & idx_q;
        busy        = (state_q != StIdle);
    end

endmodule
